cell_search_ctrl: RTL and testbench

//  Sequences the cell-search receive chain: PSS search, SSS confirm, then periodic SSB tracking.

---
 rtl/cell_search_pkg.sv | 35 +++
 rtl/cell_search_ctrl.sv | 159 +++++++++++++++
 tb/tb_cell_search_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_search_pkg.sv
// Types and constants shared by the cell-search chain (cell_search_ctrl, frame_sync, PSS_detector).
package cell_search_pkg;

  typedef enum logic [1:0] {
    PSS_MODE_SEARCH = 2'd0,
    PSS_MODE_FIND   = 2'd1,
    PSS_MODE_PAUSE  = 2'd2
  } pss_mode_t;

  typedef enum logic [1:0] {
    SEARCH     = 2'd0,
    WAIT_SSS   = 2'd1,
    TRACK_WAIT = 2'd2,
    TRACK_WIN  = 2'd3
  } cs_state_t;

  localparam int N_ID_MAX   = 1007;
  localparam int N_ID_2_MAX = 2;
  localparam int N_ID_W     = $clog2(N_ID_MAX + 1);
  localparam int N_ID_2_W   = $clog2(N_ID_2_MAX + 1);

  // N_id_2 implied by a full cell id; constant divisor, so this is plain logic.
  function automatic logic [N_ID_2_W-1:0] n_id_mod3(input logic [N_ID_W-1:0] n_id);
    return N_ID_2_W'(n_id % N_ID_W'(3));
  endfunction

  function automatic pss_mode_t mode_for_state(input cs_state_t s);
    case (s)
      SEARCH:    return PSS_MODE_SEARCH;
      TRACK_WIN: return PSS_MODE_FIND;
      default:   return PSS_MODE_PAUSE;
    endcase
  endfunction

endpackage

// File: rtl/cell_search_ctrl.sv
// Cell-search sequencer: PSS search, SSS confirm, then periodic SSB tracking with a
// timing window, declaring lock and loss. Time is counted in decimated samples.
module cell_search_ctrl
  import cell_search_pkg::*;
#(
  parameter int SSB_PERIOD  = 76800,
  parameter int WINDOW      = 8,
  parameter int MAX_MISSES  = 3,
  parameter int SSS_TIMEOUT = 4096
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                s_axis_in_tvalid,
  input  logic                N_id_2_valid_i,
  input  logic [N_ID_2_W-1:0] N_id_2_i,
  input  logic                SSS_valid_i,
  input  logic [N_ID_W-1:0]   N_id_i,
  input  logic                resync_i,
  output logic [1:0]          PSS_detector_mode_o,
  output logic [N_ID_2_W-1:0] requested_N_id_2_o,
  output logic [N_ID_W-1:0]   N_id_o,
  output logic                N_id_valid_o,
  output logic                locked_o,
  output logic                lost_o,
  output logic [1:0]          state_o
);

  localparam int CNT_W  = $clog2(SSB_PERIOD + WINDOW + 1);
  localparam int MISS_W = (MAX_MISSES > 1) ? $clog2(MAX_MISSES) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  WIN_OPEN    = CNT_W'(SSB_PERIOD - WINDOW);
  localparam logic [CNT_W-1:0]  WIN_CLOSE   = CNT_W'(SSB_PERIOD + WINDOW);
  localparam logic [CNT_W-1:0]  WIN_REALIGN = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0]  SSS_LIMIT   = CNT_W'(SSS_TIMEOUT);
  localparam logic [MISS_W-1:0] LAST_MISS   = MISS_W'(MAX_MISSES - 1);

  if (WINDOW >= SSB_PERIOD / 2 || MAX_MISSES < 1) begin : g_bad_params
    $error("cell_search_ctrl: WINDOW must be < SSB_PERIOD/2 and MAX_MISSES >= 1");
  end

  cs_state_t             state_q, state_d;
  pss_mode_t             mode_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic [N_ID_2_W-1:0]   req_q, req_d;
  logic [N_ID_W-1:0]     n_id_q, n_id_d;
  logic                  n_id_valid_q, n_id_valid_d;
  logic                  locked_q;
  logic                  lost_q, lost_d;
  logic                  sss_match;
  logic                  hit;
  logic                  is_tracking;

  assign sss_match   = n_id_mod3(N_id_i) == req_q;
  assign hit         = N_id_2_valid_i && (N_id_2_i == req_q);
  assign is_tracking = (state_q == TRACK_WAIT) || (state_q == TRACK_WIN);

  // The sample counter saturates so a stalled FSM never sees a wrapped compare.
  assign cnt_inc = (s_axis_in_tvalid && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

  // NOTE: every signal gets a default before the case; a path that skips one infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    miss_d       = miss_q;
    req_d        = req_q;
    n_id_d       = n_id_q;
    n_id_valid_d = 1'b0;
    lost_d       = 1'b0;

    if (resync_i) begin
      state_d = SEARCH;
      cnt_d   = '0;
      miss_d  = '0;
      lost_d  = is_tracking;
    end else begin
      case (state_q)
        SEARCH: begin
          if (N_id_2_valid_i) begin
            req_d   = N_id_2_i;
            cnt_d   = '0;
            state_d = WAIT_SSS;
          end
        end

        WAIT_SSS: begin
          if (SSS_valid_i && sss_match) begin
            n_id_d       = N_id_i;
            n_id_valid_d = 1'b1;
            miss_d       = '0;
            state_d      = TRACK_WAIT;
          end else if (SSS_valid_i || cnt_q == SSS_LIMIT) begin
            state_d = SEARCH;
          end
        end

        TRACK_WAIT: begin
          if (cnt_q == WIN_OPEN) state_d = TRACK_WIN;
        end

        TRACK_WIN: begin
          // A hit on the closing sample still counts; realign to the observed peak.
          if (hit) begin
            cnt_d   = '0;
            miss_d  = '0;
            state_d = TRACK_WAIT;
          end else if (cnt_q == WIN_CLOSE) begin
            cnt_d = WIN_REALIGN;
            if (miss_q == LAST_MISS) begin
              miss_d  = '0;
              lost_d  = 1'b1;
              state_d = SEARCH;
            end else begin
              miss_d  = miss_q + MISS_W'(1);
              state_d = TRACK_WAIT;
            end
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= SEARCH;
      mode_q       <= PSS_MODE_SEARCH;
      cnt_q        <= '0;
      miss_q       <= '0;
      req_q        <= '0;
      n_id_q       <= '0;
      n_id_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_for_state(state_d);
      cnt_q        <= cnt_d;
      miss_q       <= miss_d;
      req_q        <= req_d;
      n_id_q       <= n_id_d;
      n_id_valid_q <= n_id_valid_d;
      locked_q     <= (state_d == TRACK_WAIT) || (state_d == TRACK_WIN);
      lost_q       <= lost_d;
    end
  end

  assign PSS_detector_mode_o = mode_q;
  assign requested_N_id_2_o  = req_q;
  assign N_id_o              = n_id_q;
  assign N_id_valid_o        = n_id_valid_q;
  assign locked_o            = locked_q;
  assign lost_o              = lost_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_cell_search_ctrl.sv
// Bench for cell_search_ctrl: directed scenarios plus random traffic, all checked each
// cycle against a timeline model (lock status plus sample time of the last alignment).
module tb_cell_search_ctrl;
  import cell_search_pkg::*;

  localparam int P = 1000;
  localparam int W = 8;
  localparam int M = 2;
  localparam int T = 600;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       tvalid;
  logic       peak;
  logic [1:0] nid2;
  logic       sss;
  logic [9:0] nid;
  logic       resync;
  logic [1:0] mode_o;
  logic [1:0] req_o;
  logic [9:0] nid_o;
  logic       nid_valid_o;
  logic       locked_o;
  logic       lost_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  cell_search_ctrl #(
    .SSB_PERIOD (P),
    .WINDOW     (W),
    .MAX_MISSES (M),
    .SSS_TIMEOUT(T)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .s_axis_in_tvalid   (tvalid),
    .N_id_2_valid_i     (peak),
    .N_id_2_i           (nid2),
    .SSS_valid_i        (sss),
    .N_id_i             (nid),
    .resync_i           (resync),
    .PSS_detector_mode_o(mode_o),
    .requested_N_id_2_o (req_o),
    .N_id_o             (nid_o),
    .N_id_valid_o       (nid_valid_o),
    .locked_o           (locked_o),
    .lost_o             (lost_o),
    .state_o            (state_o)
  );

  // Timeline model: now_t counts cycles (tvalid is always 1), ref_t is the cycle at
  // which the sample count was zero; the window is "count past P-W" while locked.
  int now_t        = 0;
  int ref_t        = 0;
  int misses       = 0;
  bit m_locked     = 0;
  bit m_confirming = 0;
  int m_req        = 0;
  int m_id         = 0;
  bit e_valid      = 0;
  bit e_lost       = 0;

  function automatic int count_now();
    return now_t - ref_t;
  endfunction

  function automatic int exp_state();
    if (m_locked) return (count_now() > P - W) ? 3 : 2;
    if (m_confirming) return 1;
    return 0;
  endfunction

  function automatic int exp_mode();
    case (exp_state())
      0:       return 0;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  task automatic model_step();
    int c;
    c = now_t - ref_t;
    e_valid = 0;
    e_lost  = 0;
    if (reset_i) begin
      m_locked = 0; m_confirming = 0; m_req = 0; m_id = 0; misses = 0;
      ref_t = now_t + 1;
    end else if (resync) begin
      e_lost = m_locked;
      m_locked = 0;
      m_confirming = 0;
    end else if (m_locked) begin
      if (c > P - W && peak && int'(nid2) == m_req) begin
        ref_t  = now_t + 1;
        misses = 0;
      end else if (c == P + W) begin
        ref_t  = now_t + 1 - W;
        misses = misses + 1;
        if (misses == M) begin
          m_locked = 0;
          e_lost   = 1;
          misses   = 0;
        end
      end
    end else if (m_confirming) begin
      if (sss) begin
        m_confirming = 0;
        if (int'(nid) % 3 == m_req) begin
          m_locked = 1;
          misses   = 0;
          m_id     = int'(nid);
          e_valid  = 1;
        end
      end else if (c == T) begin
        m_confirming = 0;
      end
    end else if (peak) begin
      m_confirming = 1;
      m_req        = int'(nid2);
      ref_t        = now_t + 1;
    end
    now_t = now_t + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    check("state", 32'(state_o), 32'(exp_state()));
    check("mode", 32'(mode_o), 32'(exp_mode()));
    check("requested", 32'(req_o), 32'(m_req));
    check("n_id", 32'(nid_o), 32'(m_id));
    check("n_id_valid", 32'(nid_valid_o), 32'(e_valid));
    check("locked", 32'(locked_o), 32'(m_locked));
    check("lost", 32'(lost_o), 32'(e_lost));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic idle_until(input int k);
    int guard;
    guard = 0;
    while (count_now() != k && guard < 3000) begin
      cycle();
      guard++;
    end
    if (count_now() != k) begin
      n_checks++;
      n_fails++;
      $error("FAIL wait_count: observed count %0d, expected %0d", count_now(), k);
    end
  endtask

  task automatic pss(input int id2);
    peak = 1'b1;
    nid2 = 2'(id2);
    cycle();
    peak = 1'b0;
  endtask

  task automatic sss_result(input int id);
    sss = 1'b1;
    nid = 10'(id);
    cycle();
    sss = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    tvalid  = 1'b1;
    peak    = 1'b0;
    nid2    = '0;
    sss     = 1'b0;
    nid     = '0;
    resync  = 1'b0;

    idle(2);
    check("rst_state", 32'(state_o), 0);
    check("rst_mode", 32'(mode_o), 0);
    check("rst_locked", 32'(locked_o), 0);
    check("rst_n_id", 32'(nid_o), 0);
    reset_i = 1'b0;
    idle(5);

    // Acquire: peak N_id_2=1, SSS 301 at count 300
    pss(1);
    check("t1_mode_pause", 32'(mode_o), 2);
    check("t1_requested", 32'(req_o), 1);
    idle_until(300);
    sss_result(301);
    check("t1_n_id_valid", 32'(nid_valid_o), 1);
    check("t1_n_id", 32'(nid_o), 301);
    check("t1_locked", 32'(locked_o), 1);
    check("t1_mode", 32'(mode_o), 2);
    cycle();
    check("t1_valid_one_cycle", 32'(nid_valid_o), 0);

    // Window opens after count 992; late hit at 1003 realigns
    idle_until(992);
    check("t2_before_window", 32'(mode_o), 2);
    cycle();
    check("t2_window_open", 32'(mode_o), 1);
    idle_until(1003);
    pss(1);
    check("t2_hit_mode", 32'(mode_o), 2);
    check("t2_hit_state", 32'(state_o), 2);
    idle_until(992);
    check("t2_realigned_closed", 32'(mode_o), 2);
    cycle();
    check("t2_realigned_open", 32'(mode_o), 1);

    // Two missed SSBs drop lock
    idle_until(1008);
    check("t3_window_still_open", 32'(mode_o), 1);
    cycle();
    check("t3_miss1_mode", 32'(mode_o), 2);
    check("t3_miss1_locked", 32'(locked_o), 1);
    check("t3_miss1_no_lost", 32'(lost_o), 0);
    idle_until(992);
    cycle();
    check("t3_window2_open", 32'(mode_o), 1);
    idle_until(1008);
    cycle();
    check("t3_lost_pulse", 32'(lost_o), 1);
    check("t3_lost_mode", 32'(mode_o), 0);
    check("t3_lost_locked", 32'(locked_o), 0);
    cycle();
    check("t3_lost_one_cycle", 32'(lost_o), 0);

    // SSS mismatch and SSS timeout both return to SEARCH
    pss(1);
    idle(10);
    sss_result(302);
    check("t4_mismatch_state", 32'(state_o), 0);
    check("t4_mismatch_locked", 32'(locked_o), 0);
    check("t4_n_id_holds", 32'(nid_o), 301);
    pss(1);
    idle_until(600);
    check("t4_waiting", 32'(state_o), 1);
    cycle();
    check("t4_timeout_state", 32'(state_o), 0);
    check("t4_timeout_mode", 32'(mode_o), 0);

    // Foreign N_id_2 ignored in window; hit on the closing sample wins
    pss(1);
    idle(3);
    sss_result(4);
    check("t5_n_id", 32'(nid_o), 4);
    idle_until(1000);
    pss(0);
    check("t5_foreign_ignored", 32'(state_o), 3);
    idle_until(1008);
    pss(1);
    check("t5_edge_hit_state", 32'(state_o), 2);
    check("t5_edge_hit_locked", 32'(locked_o), 1);
    check("t5_edge_hit_no_lost", 32'(lost_o), 0);
    idle_until(992);
    cycle();
    check("t5_realigned_open", 32'(mode_o), 1);
    idle_until(1000);
    pss(1);

    // resync while locked, resync against a peak in SEARCH, reset in TRACK_WIN
    idle(5);
    resync = 1'b1;
    cycle();
    resync = 1'b0;
    check("t6_resync_lost", 32'(lost_o), 1);
    check("t6_resync_state", 32'(state_o), 0);
    check("t6_resync_n_id_holds", 32'(nid_o), 4);
    resync = 1'b1;
    peak   = 1'b1;
    nid2   = 2'd2;
    cycle();
    resync = 1'b0;
    peak   = 1'b0;
    check("t6_resync_beats_peak", 32'(state_o), 0);
    check("t6_resync_no_lost", 32'(lost_o), 0);
    check("t6_requested_holds", 32'(req_o), 1);
    pss(2);
    sss_result(5);
    idle_until(995);
    check("t6_in_window", 32'(state_o), 3);
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    check("t6_reset_state", 32'(state_o), 0);
    check("t6_reset_mode", 32'(mode_o), 0);
    check("t6_reset_requested", 32'(req_o), 0);
    check("t6_reset_n_id", 32'(nid_o), 0);
    check("t6_reset_locked", 32'(locked_o), 0);

    // Random traffic, biased toward the window while locked and toward SSS while confirming
    for (int i = 0; i < 20000; i++) begin
      peak    = 1'b0;
      sss     = 1'b0;
      resync  = 1'b0;
      reset_i = 1'b0;
      if (m_locked && count_now() > P - W) begin
        if ($urandom_range(19) == 0) begin
          peak = 1'b1;
          nid2 = ($urandom_range(3) != 0) ? 2'(m_req) : 2'($urandom_range(2));
        end
      end else if ($urandom_range(299) == 0) begin
        peak = 1'b1;
        nid2 = 2'($urandom_range(2));
      end
      if (m_confirming && $urandom_range(199) == 0) begin
        sss = 1'b1;
        nid = ($urandom_range(2) != 0) ? 10'(3 * $urandom_range(335) + m_req)
                                       : 10'($urandom_range(1007));
      end
      if ($urandom_range(2999) == 0) resync = 1'b1;
      if ($urandom_range(7999) == 0) reset_i = 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
